ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM word-address width (16 words).
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Ports req0/req1  input  1 each  access request from the CPU execute stage (port 0) and from the memory loader (port 1).
REQ-006 Ports we0/we1  input  1 each  1 = write, 0 = read, per port.
REQ-007 Ports addr0/addr1  input  ADDR_W each  word address, per port.
REQ-008 Ports wdata0/wdata1  input  DATA_W each  write data, per port.
REQ-009 Ports done0/done1  output  1 each  one-cycle completion pulse, per port.
REQ-010 Port rdata  output  DATA_W  read data; valid only in a cycle where done0 or done1 is high.
REQ-011 Port ram_ce  output  1  RAM chip enable.
REQ-012 Port ram_rw  output  1  1 = read, 0 = write.
REQ-013 Port ram_addr  output  ADDR_W  RAM address.
REQ-014 Port ram_wdata  output  DATA_W  RAM write data.
REQ-015 Port ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_ce with ram_rw=1.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP, all registered.
- IDLE: no request pending.
- ACCESS: RAM being driven.
- RESP: capture the read data and complete.
REQ-017 Requester rules:
- A requester holds req, we, addr and wdata stable from assertion until its done pulse.
- It drops req, or presents a new request, in the cycle after done.
REQ-018 IDLE -> ACCESS transition:
- Taken when req0 or req1 is high.
- The winner's id, we, addr and wdata are latched into internal registers at that edge.
REQ-019 Arbitration SHALL be round-robin.
- If both requests are high, the winner is the port not granted last.
- If one request is high, that port wins.
- The last-granted pointer resets to 1, so port 0 wins the first tie.
REQ-020 In ACCESS, the outputs SHALL be driven from the latched registers:
- ram_ce=1
- ram_rw=~we
- ram_addr and ram_wdata from the latched values.
REQ-021 ACCESS SHALL always advance to RESP after exactly one cycle.
REQ-022 In RESP:
- done of the latched port is pulsed high for one cycle.
- rdata = ram_rdata for a read; rdata = 0 for a write.
REQ-023 RESP -> next state:
- If any request other than the just-completed one is high, the next winner is latched per REQ-019 and the FSM goes to ACCESS (back-to-back; the just-completed port's req is ignored in that cycle).
- Otherwise the FSM goes to IDLE.
REQ-024 Latency SHALL be fixed:
- Request seen high in IDLE at edge N -> ram_ce high in cycle N+1 -> done high in cycle N+2.
- Sustained throughput is one access per 2 cycles.
REQ-025 Outside ACCESS:
- ram_ce=0 and ram_rw=1.
- ram_addr and ram_wdata hold their last values.
REQ-026 done0 and done1 SHALL never be high in the same cycle.
REQ-027 A port with req held high SHALL be completed within 4 cycles of the edge at which it was first sampled high (starvation bound).
REQ-028 Address values SHALL pass unmodified; there is no wrap or range check (ADDR_W bits cover the whole RAM).

Reset
REQ-029 reset_n low SHALL asynchronously force:
- state IDLE
- done0=done1=0, rdata=0
- ram_ce=0, ram_rw=1, ram_addr=0, ram_wdata=0
- last-granted pointer=1
REQ-030 Reset asserted in ACCESS or RESP SHALL abort the access with no done pulse; the requester reissues after reset.
REQ-031 After reset_n deasserts, the first request SHALL be accepted at the first rising edge at which reset_n is high.

Verification
REQ-032 Single write: port1 writes 0xBEEF to address 3.
- Expected: ram_ce=1, ram_rw=0, ram_addr=3, ram_wdata=0xBEEF one cycle later.
- Expected: done1 pulses the next cycle, with rdata=0.
REQ-033 Read-back: RAM word 3 = 0xBEEF, port0 reads address 3.
- Expected: done0 two cycles after request, with rdata=0xBEEF.
REQ-034 Tie after reset: req0 and req1 rise together, port0 reads address 1 and port1 writes address 2.
- Expected: port0 served first, then port1 back-to-back.
- Expected: done0 at cycle +2, done1 at cycle +4, no IDLE cycle between.
REQ-035 Fairness: req0 and req1 held high for 8 accesses.
- Expected: grants alternate 0,1,0,1,...
- Expected: each done spaced 2 cycles apart, never simultaneous.
REQ-036 Reset mid-access: reset_n pulsed low while in ACCESS.
- Expected: ram_ce=0 immediately, no done pulse.
- Expected: the reissued request completes with the normal 2-cycle latency.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter onto a single-port synchronous RAM.
module ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_ce,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state;
   logic last, cur_id, cur_we, rd_pend, gid, go;
   // from RESP only the port that was not just served may be granted
   assign gid   = (state == IDLE) ? ((req0 & req1) ? ~last : req1) : ~cur_id;
   assign go    = (state == IDLE || state == RESP) && (gid ? req1 : req0);
   assign rdata = rd_pend ? ram_rdata : '0;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         cur_id    <= 1'b0;
         cur_we    <= 1'b0;
         rd_pend   <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         ram_ce    <= 1'b0;
         ram_rw    <= 1'b1;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         done0   <= 1'b0;
         done1   <= 1'b0;
         rd_pend <= 1'b0;
         ram_ce  <= 1'b0;
         ram_rw  <= 1'b1;
         if (go) begin
            state     <= ACCESS;
            last      <= gid;
            cur_id    <= gid;
            cur_we    <= gid ? we1 : we0;
            ram_ce    <= 1'b1;
            ram_rw    <= ~(gid ? we1 : we0);
            ram_addr  <= gid ? addr1 : addr0;
            ram_wdata <= gid ? wdata1 : wdata0;
         end else if (state == ACCESS) begin
            state   <= RESP;
            done0   <= ~cur_id;
            done1   <= cur_id;
            rd_pend <= ~cur_we;
         end else begin
            state <= IDLE;
         end
      end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a RAM model and shadow memory.
module tb_ram_arbiter;
   localparam int AW = 4;
   localparam int DW = 16;
   logic clock = 1'b0;
   logic reset_n = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic done0, done1, ram_ce, ram_rw;
   logic [DW-1:0] rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] mem [16];
   logic [DW-1:0] shadow [16];
   bit known [16];
   int total = 0, bad = 0;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rdata(rdata),
      .ram_ce(ram_ce), .ram_rw(ram_rw), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clock = ~clock;

   // synchronous RAM: read data appears the cycle after the enable
   always @(posedge clock)
      if (ram_ce === 1'b1) begin
         if (ram_rw) ram_rdata <= mem[ram_addr];
         else mem[ram_addr] <= ram_wdata;
      end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({done0, done1, ram_ce, ram_rw} !== 4'b0001) begin
         bad++; $display("FAIL reset_ctl got=%b exp=0001", {done0, done1, ram_ce, ram_rw});
      end
      total++;
      if ({rdata, ram_addr, ram_wdata} !== 36'h0) begin
         bad++; $display("FAIL reset_data got=%h exp=0", {rdata, ram_addr, ram_wdata});
      end
      tick;
      total++;
      if ({done0, done1, ram_ce} !== 3'b000) begin
         bad++; $display("FAIL reset_hold got=%b exp=000", {done0, done1, ram_ce});
      end
      reset_n = 1'b1;
      tick;
      total++;
      if (ram_ce !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset ram_ce got=%b exp=0", ram_ce);
      end
   endtask

   task automatic test_single_write;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 16'hBEEF;
      tick;
      total++;
      if ({ram_ce, ram_rw, ram_addr, ram_wdata, done0, done1} !== {1'b1, 1'b0, 4'd3, 16'hBEEF, 2'b00}) begin
         bad++; $display("FAIL wr_access got=%h exp=%h", {ram_ce, ram_rw, ram_addr, ram_wdata, done0, done1},
                         {1'b1, 1'b0, 4'd3, 16'hBEEF, 2'b00});
      end
      tick;
      total++;
      if ({done0, done1, rdata, ram_ce, ram_rw} !== {2'b01, 16'h0, 2'b01}) begin
         bad++; $display("FAIL wr_done got=%h exp=%h", {done0, done1, rdata, ram_ce, ram_rw}, {2'b01, 16'h0, 2'b01});
      end
      tick;
      req1 = 1'b0;
      total++;
      if ({done0, done1, ram_ce, ram_rw, ram_addr, ram_wdata} !== {4'b0001, 4'd3, 16'hBEEF}) begin
         bad++; $display("FAIL wr_idle_hold got=%h exp=%h", {done0, done1, ram_ce, ram_rw, ram_addr, ram_wdata},
                         {4'b0001, 4'd3, 16'hBEEF});
      end
      shadow[3] = 16'hBEEF; known[3] = 1'b1;
   endtask

   task automatic test_read_back;
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
      tick;
      total++;
      if ({ram_ce, ram_rw, ram_addr, done0, done1} !== {2'b11, 4'd3, 2'b00}) begin
         bad++; $display("FAIL rd_access got=%h exp=%h", {ram_ce, ram_rw, ram_addr, done0, done1}, {2'b11, 4'd3, 2'b00});
      end
      tick;
      total++;
      if ({done0, done1, rdata} !== {2'b10, 16'hBEEF}) begin
         bad++; $display("FAIL rd_done got=%h exp=%h", {done0, done1, rdata}, {2'b10, 16'hBEEF});
      end
      tick;
      req0 = 1'b0;
      total++;
      if ({done0, done1, ram_ce} !== 3'b000) begin
         bad++; $display("FAIL rd_idle got=%b exp=000", {done0, done1, ram_ce});
      end
   endtask

   task automatic test_tie;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 16'h1111;
      tick; tick; tick;
      req0 = 1'b0;
      #2 reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 16'h2222;
      tick;
      total++;
      if ({ram_ce, ram_rw, ram_addr} !== {2'b11, 4'd1}) begin
         bad++; $display("FAIL tie_first got=%h exp=%h", {ram_ce, ram_rw, ram_addr}, {2'b11, 4'd1});
      end
      tick;
      total++;
      if ({done0, done1, rdata} !== {2'b10, 16'h1111}) begin
         bad++; $display("FAIL tie_done0 got=%h exp=%h", {done0, done1, rdata}, {2'b10, 16'h1111});
      end
      tick;
      req0 = 1'b0;
      total++;
      if ({ram_ce, ram_rw, ram_addr, ram_wdata, done0, done1} !== {2'b10, 4'd2, 16'h2222, 2'b00}) begin
         bad++; $display("FAIL tie_b2b got=%h exp=%h", {ram_ce, ram_rw, ram_addr, ram_wdata, done0, done1},
                         {2'b10, 4'd2, 16'h2222, 2'b00});
      end
      tick;
      total++;
      if ({done0, done1, rdata} !== {2'b01, 16'h0}) begin
         bad++; $display("FAIL tie_done1 got=%h exp=%h", {done0, done1, rdata}, {2'b01, 16'h0});
      end
      tick;
      req1 = 1'b0;
      total++;
      if ({done0, done1, ram_ce} !== 3'b000) begin
         bad++; $display("FAIL tie_idle got=%b exp=000", {done0, done1, ram_ce});
      end
      shadow[1] = 16'h1111; known[1] = 1'b1;
      shadow[2] = 16'h2222; known[2] = 1'b1;
   endtask

   task automatic run_traffic(input int cycles, input int rate, input bit strict, output int n_done);
      bit pend[2], hold[2], wr[2];
      logic dn, p_ce, p_rw;
      logic [AW-1:0] ad[2], p_ad;
      logic [DW-1:0] wd[2], p_wd, exp_rd;
      int age[2];
      int cyc, last_p, last_c;
      cyc = 0; last_p = -1; last_c = 0; n_done = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; hold[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; age[p] = 0;
      end
      forever begin
         for (int p = 0; p < 2; p++)
            if (!pend[p] && !hold[p] && cyc < cycles && $urandom_range(99) < rate) begin
               pend[p] = 1'b1; age[p] = 0;
               wr[p] = 1'($urandom); ad[p] = AW'($urandom); wd[p] = DW'($urandom);
            end
         req0 = pend[0] | hold[0]; we0 = wr[0]; addr0 = ad[0]; wdata0 = wd[0];
         req1 = pend[1] | hold[1]; we1 = wr[1]; addr1 = ad[1]; wdata1 = wd[1];
         if (cyc >= cycles && !(pend[0] | pend[1] | hold[0] | hold[1])) break;
         if (cyc >= cycles + 40) begin
            total++; bad++; $display("FAIL traffic_drain pending=%b%b exp=00", pend[1], pend[0]);
            break;
         end
         p_ce = ram_ce; p_rw = ram_rw; p_ad = ram_addr; p_wd = ram_wdata;
         tick;
         cyc++;
         total++;
         if ((done0 & done1) !== 1'b0) begin
            bad++; $display("FAIL both_done got=%b%b exp=not 11", done0, done1);
         end
         for (int p = 0; p < 2; p++) begin
            if (pend[p]) age[p]++;
            dn = p ? done1 : done0;
            hold[p] = 1'b0;
            if (dn === 1'b1) begin
               n_done++;
               total++;
               if (!pend[p]) begin
                  bad++; $display("FAIL spurious_done port=%0d got=1 exp=0", p);
               end else begin
                  total++;
                  if (age[p] > 4) begin
                     bad++; $display("FAIL latency port=%0d got=%0d exp<=4", p, age[p]);
                  end
                  total++;
                  if ({p_ce, p_rw, p_ad} !== {1'b1, ~wr[p], ad[p]} || (wr[p] && p_wd !== wd[p])) begin
                     bad++; $display("FAIL ram_cycle port=%0d got=%b %b %h %h exp=1 %b %h %h",
                                     p, p_ce, p_rw, p_ad, p_wd, ~wr[p], ad[p], wd[p]);
                  end
                  exp_rd = wr[p] ? '0 : shadow[ad[p]];
                  if (wr[p] || known[ad[p]]) begin
                     total++;
                     if (rdata !== exp_rd) begin
                        bad++; $display("FAIL rdata port=%0d addr=%h got=%h exp=%h", p, ad[p], rdata, exp_rd);
                     end
                  end
                  if (wr[p]) begin
                     shadow[ad[p]] = wd[p]; known[ad[p]] = 1'b1;
                  end
                  if (strict && last_p >= 0) begin
                     total++;
                     if (p == last_p || cyc - last_c != 2) begin
                        bad++; $display("FAIL fair_order got=port%0d gap%0d exp=port%0d gap2", p, cyc - last_c, 1 - last_p);
                     end
                  end
                  last_p = p; last_c = cyc;
                  pend[p] = 1'b0; hold[p] = 1'b1;
               end
            end else if (pend[p] && age[p] > 4) begin
               total++; bad++; $display("FAIL starve port=%0d got=age%0d exp<=4", p, age[p]);
               pend[p] = 1'b0;
            end
         end
      end
   endtask

   task automatic test_fairness;
      int n;
      run_traffic(16, 100, 1'b1, n);
      total++;
      if (n < 8) begin
         bad++; $display("FAIL fair_count got=%0d exp>=8", n);
      end
   endtask

   task automatic test_reset_mid;
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 16'h5555;
      tick;
      total++;
      if ({ram_ce, ram_rw, ram_addr} !== {2'b10, 4'd5}) begin
         bad++; $display("FAIL mid_access got=%h exp=%h", {ram_ce, ram_rw, ram_addr}, {2'b10, 4'd5});
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({ram_ce, ram_rw, done0, done1} !== 4'b0100) begin
         bad++; $display("FAIL mid_abort got=%b exp=0100", {ram_ce, ram_rw, done0, done1});
      end
      tick;
      total++;
      if ({ram_ce, done0, done1} !== 3'b000) begin
         bad++; $display("FAIL mid_no_done got=%b exp=000", {ram_ce, done0, done1});
      end
      reset_n = 1'b1;
      tick;
      total++;
      if ({ram_ce, ram_rw, ram_addr, ram_wdata} !== {2'b10, 4'd5, 16'h5555}) begin
         bad++; $display("FAIL mid_reissue got=%h exp=%h", {ram_ce, ram_rw, ram_addr, ram_wdata}, {2'b10, 4'd5, 16'h5555});
      end
      tick;
      total++;
      if ({done0, done1, rdata} !== {2'b10, 16'h0}) begin
         bad++; $display("FAIL mid_done got=%h exp=%h", {done0, done1, rdata}, {2'b10, 16'h0});
      end
      tick;
      req0 = 1'b0;
      shadow[5] = 16'h5555; known[5] = 1'b1;
   endtask

   task automatic test_random;
      int n;
      run_traffic(300, 40, 1'b0, n);
      run_traffic(200, 85, 1'b0, n);
      total++;
      if (n < 50) begin
         bad++; $display("FAIL random_count got=%0d exp>=50", n);
      end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_read_back;
      test_tie;
      test_fairness;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
